fetch_issue_ctrl: RTL and testbench

Front-end sequencer for the Tomasulo core. It drives the PC into the instruction memory, absorbs the one-cycle read latency, and buffers fetched words in a small in-order queue. It then dispatches each instruction to the add or multiply reservation-station group with a valid/ready handshake. It sits between `instruction_set` (PC in, 16-bit word out one `clk1` edge later) and the reservation stations.

---
 rtl/tomasulo_pkg.sv | 33 +++
 rtl/issue_queue.sv | 68 ++++++
 rtl/fetch_issue_ctrl.sv | 136 +++++++++++++
 tb/tb_fetch_issue_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo front end: opcodes, instruction fields,
// functional-unit selector and the fetch/issue sequencer states.
package tomasulo_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;

    localparam int OPC_HI = 15;
    localparam int OPC_LO = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int RS1_HI = 7;
    localparam int RS1_LO = 4;
    localparam int RS2_HI = 3;
    localparam int RS2_LO = 0;

    // Opcode bit 1 (instruction bit 13) separates MUL from ADD/SUB.
    localparam int UNIT_BIT = 13;

    typedef enum logic {
        UNIT_ADD = 1'b0,
        UNIT_MUL = 1'b1
    } unit_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/issue_queue.sv
// In-order FIFO of {fetch tag, instruction}; the head entry is read straight
// from the storage registers so the issue outputs carry no ready-input path.
module issue_queue #(
    parameter int PC_W   = 4,
    parameter int INSN_W = 16,
    parameter int QDEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [PC_W-1:0]          push_tag_i,
    input  logic [INSN_W-1:0]        push_instr_i,
    output logic [PC_W-1:0]          head_tag_o,
    output logic [INSN_W-1:0]        head_instr_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(QDEPTH):0]  count_o
);

    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(QDEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

    logic [PC_W+INSN_W-1:0] mem_q [QDEPTH];
    logic [AW-1:0]          wr_ptr_q;
    logic [AW-1:0]          rd_ptr_q;
    logic [AW:0]            count_q;
    logic                   do_push;
    logic                   do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // A pop frees the slot being written, so push-while-full is legal when paired with a pop.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign {head_tag_o, head_instr_o} = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < QDEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            assert (!(push_i && full_o && !pop_i));
            if (do_push) begin
                mem_q[wr_ptr_q] <= {push_tag_i, push_instr_i};
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_issue_ctrl.sv
// Front-end sequencer: walks the PC through instruction memory, absorbs the
// one-cycle read latency and dispatches queued words to the add/mul groups.
module fetch_issue_ctrl
    import tomasulo_pkg::*;
#(
    parameter int PC_W   = 4,
    parameter int INSN_W = 16,
    parameter int QDEPTH = 4
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start,
    input  logic [PC_W:0]     prog_len,
    output logic [PC_W-1:0]   pc,
    input  logic [INSN_W-1:0] mem_instr,
    input  logic              add_rs_ready,
    input  logic              mul_rs_ready,
    output logic              issue_valid,
    output logic [INSN_W-1:0] issue_instr,
    output logic              issue_unit,
    output logic [PC_W-1:0]   issue_tag,
    output logic              busy,
    output logic              done
);

    localparam int AW = $clog2(QDEPTH);
    localparam logic [AW+1:0] OCC_LIMIT = (AW+2)'(QDEPTH);
    localparam logic [PC_W:0] LEN_ONE   = (PC_W+1)'(1);
    localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

    state_e            state_q;
    logic [PC_W-1:0]   pc_q;
    logic [PC_W:0]     len_q;
    logic              inflight_q;
    logic [PC_W-1:0]   inflight_pc_q;
    logic              busy_q;
    logic              done_q;

    logic [AW:0]       q_count;
    logic              q_full;
    logic              q_empty;
    logic [PC_W-1:0]   head_tag;
    logic [INSN_W-1:0] head_instr;
    logic [AW+1:0]     occ_d;
    logic              launch_d;
    logic              last_fetch_d;
    logic              pop_d;
    unit_e             head_unit;

    // Entries already queued plus the one still in the memory pipeline must leave room.
    assign occ_d        = {1'b0, q_count} + {{(AW+1){1'b0}}, inflight_q};
    assign launch_d     = (state_q == RUN) && !q_full && (occ_d < OCC_LIMIT);
    assign last_fetch_d = ({1'b0, pc_q} == (len_q - LEN_ONE));

    assign head_unit = unit_e'(head_instr[UNIT_BIT]);
    assign pop_d     = !q_empty && ((head_unit == UNIT_MUL) ? mul_rs_ready : add_rs_ready);

    issue_queue #(
        .PC_W   (PC_W),
        .INSN_W (INSN_W),
        .QDEPTH (QDEPTH)
    ) u_issue_queue (
        .clk_i        (clk1),
        .rst_i        (rst),
        .push_i       (inflight_q),
        .pop_i        (pop_d),
        .push_tag_i   (inflight_pc_q),
        .push_instr_i (mem_instr),
        .head_tag_o   (head_tag),
        .head_instr_o (head_instr),
        .full_o       (q_full),
        .empty_o      (q_empty),
        .count_o      (q_count)
    );

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            len_q         <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            inflight_q <= launch_d;
            if (launch_d) begin
                inflight_pc_q <= pc_q;
                pc_q          <= pc_q + PC_ONE;
            end
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        len_q <= prog_len;
                        pc_q  <= '0;
                        if (prog_len == '0) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (launch_d && last_fetch_d) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (q_empty && !inflight_q) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign pc          = pc_q;
    assign issue_valid = !q_empty;
    assign issue_instr = head_instr;
    assign issue_unit  = head_unit;
    assign issue_tag   = head_tag;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// Directed and randomized checks of fetch_issue_ctrl against an in-order
// issue model: program k must issue tags 0..k-1 once each, in order.
module tb_fetch_issue_ctrl;

    localparam int PC_W   = 4;
    localparam int INSN_W = 16;
    localparam int QDEPTH = 4;
    localparam int NMEM   = 16;

    logic              clk1 = 1'b0;
    logic              rst;
    logic              start;
    logic [PC_W:0]     prog_len;
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] mem_instr;
    logic              add_rs_ready;
    logic              mul_rs_ready;
    logic              issue_valid;
    logic [INSN_W-1:0] issue_instr;
    logic              issue_unit;
    logic [PC_W-1:0]   issue_tag;
    logic              busy;
    logic              done;

    logic [INSN_W-1:0] mem [NMEM];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int cur_len;
    int exp_tag;
    int first_pop_edge;
    int last_pop_edge;
    bit prev_hold;
    logic [INSN_W-1:0] prev_instr;
    logic [PC_W-1:0]   prev_tag;

    fetch_issue_ctrl #(
        .PC_W   (PC_W),
        .INSN_W (INSN_W),
        .QDEPTH (QDEPTH)
    ) dut (
        .clk1         (clk1),
        .rst          (rst),
        .start        (start),
        .prog_len     (prog_len),
        .pc           (pc),
        .mem_instr    (mem_instr),
        .add_rs_ready (add_rs_ready),
        .mul_rs_ready (mul_rs_ready),
        .issue_valid  (issue_valid),
        .issue_instr  (issue_instr),
        .issue_unit   (issue_unit),
        .issue_tag    (issue_tag),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk1 = ~clk1;

    // Instruction memory with one-edge read latency.
    always @(posedge clk1) begin
        cyc       <= cyc + 1;
        mem_instr <= mem[pc];
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: observed no finish, expected finish");
        $fatal(1, "global timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_readies(input int mode, input int k);
        case (mode)
            0: begin add_rs_ready = 1'b1; mul_rs_ready = 1'b1; end
            1: begin add_rs_ready = 1'b1; mul_rs_ready = (k >= 10); end
            2: begin add_rs_ready = (k % 2 == 0); mul_rs_ready = (k % 2 == 1); end
            default: begin
                add_rs_ready = 1'($urandom_range(0, 1));
                mul_rs_ready = 1'($urandom_range(0, 1));
            end
        endcase
    endtask

    // Called at a falling edge: checks the head against the model, predicts the pop, advances one cycle.
    task automatic monitor_step(input int mode, input int k);
        bit pop;
        set_readies(mode, k);
        if (issue_valid) begin
            check("spurious_issue", 32'(exp_tag < cur_len), 1);
            if (exp_tag < cur_len) begin
                check("issue_tag", 32'(issue_tag), 32'(exp_tag));
                check("issue_instr", 32'(issue_instr), 32'(mem[exp_tag]));
                check("issue_unit", 32'(issue_unit), 32'(mem[exp_tag][13]));
            end
        end
        if (prev_hold) begin
            check("hold_valid", 32'(issue_valid), 1);
            check("hold_instr", 32'(issue_instr), 32'(prev_instr));
            check("hold_tag", 32'(issue_tag), 32'(prev_tag));
        end
        pop = issue_valid && (exp_tag < cur_len) &&
              (mem[exp_tag][13] ? mul_rs_ready : add_rs_ready);
        prev_hold  = issue_valid && !pop;
        prev_instr = issue_instr;
        prev_tag   = issue_tag;
        if (pop) begin
            exp_tag++;
            last_pop_edge = cyc + 1;
            if (first_pop_edge < 0) first_pop_edge = cyc + 1;
        end
        @(negedge clk1);
    endtask

    task automatic run_prog(input int len, input int mode);
        int k;
        int start_edge;
        cur_len        = len;
        exp_tag        = 0;
        first_pop_edge = -1;
        last_pop_edge  = -1;
        prev_hold      = 1'b0;
        prog_len       = (PC_W+1)'(len);
        start          = 1'b1;
        start_edge     = cyc + 1;
        monitor_step(mode, 0);
        start          = 1'b0;
        k = 1;
        while (!done && k < 300) begin
            if (mode == 1 && k == 9) begin
                check("stall_pc", 32'(pc), QDEPTH);
                check("stall_valid", 32'(issue_valid), 1);
                check("stall_tag", 32'(issue_tag), 0);
            end
            monitor_step(mode, k);
            k++;
        end
        check("run_done", 32'(done), 1);
        check("all_issued", 32'(exp_tag), 32'(len));
        check("done_after_last_issue", 32'(cyc), 32'(last_pop_edge + 1));
        check("busy_at_done", 32'(busy), 0);
        check("valid_at_done", 32'(issue_valid), 0);
        check("pc_at_done", 32'(pc), 32'(len % NMEM));
        if (mode == 0) begin
            check("first_issue_latency", 32'(first_pop_edge - start_edge), 3);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk1);
            check("no_extra_fetch_pc", 32'(pc), 32'(len % NMEM));
            check("no_issue_after_done", 32'(issue_valid), 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"}, 32'(pc), 0);
        check({tag, "_valid"}, 32'(issue_valid), 0);
        check({tag, "_instr"}, 32'(issue_instr), 0);
        check({tag, "_unit"}, 32'(issue_unit), 0);
        check({tag, "_tag"}, 32'(issue_tag), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        prog_len     = '0;
        add_rs_ready = 1'b0;
        mul_rs_ready = 1'b0;
        for (int i = 0; i < NMEM; i++) mem[i] = '0;
        repeat (3) @(negedge clk1);
        rst = 1'b0;
        check_reset_outputs("reset");

        // Zero-length program: straight to DONE, nothing fetched or issued.
        prog_len = '0;
        start    = 1'b1;
        @(negedge clk1);
        start = 1'b0;
        check("zero_done", 32'(done), 1);
        check("zero_busy", 32'(busy), 0);
        for (int i = 0; i < 4; i++) begin
            check("zero_valid", 32'(issue_valid), 0);
            check("zero_pc", 32'(pc), 0);
            @(negedge clk1);
        end

        // Basic run.
        mem[0] = 16'h2123; mem[1] = 16'h0345; mem[2] = 16'h0267; mem[3] = 16'h089A;
        run_prog(4, 0);

        // Mul backpressure on the head; queue fills and fetch stalls.
        for (int i = 4; i < NMEM; i++) mem[i] = 16'(i * 16'h1111);
        run_prog(8, 1);

        // Full-length wrap with alternating readies.
        for (int i = 0; i < NMEM; i++) mem[i] = 16'($urandom);
        run_prog(16, 2);

        // Randomized programs and readies.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NMEM; i++) mem[i] = 16'($urandom);
            run_prog(int'($urandom_range(1, 16)), 3);
        end

        // Reset while draining with two mul entries stuck in the queue.
        for (int i = 0; i < NMEM; i++) mem[i] = 16'h2000 | 16'(i);
        add_rs_ready = 1'b1;
        mul_rs_ready = 1'b0;
        prog_len     = 5'd2;
        start        = 1'b1;
        @(negedge clk1);
        start = 1'b0;
        repeat (6) @(negedge clk1);
        check("drain_busy", 32'(busy), 1);
        check("drain_valid", 32'(issue_valid), 1);
        check("drain_head_tag", 32'(issue_tag), 0);
        check("drain_pc", 32'(pc), 2);
        rst = 1'b1;
        @(negedge clk1);
        rst = 1'b0;
        check_reset_outputs("midreset");
        @(negedge clk1);
        check_reset_outputs("postreset");

        // Restart after reset refetches from PC 0.
        mem[0] = 16'h0111; mem[1] = 16'h2222; mem[2] = 16'h1333;
        run_prog(3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
